dkong_audio_mixer: RTL and testbench

//  Parametrised N-channel audio mixer for the sound board.
//  - Generates the oversample strobe that drives per-sample sources such as dk_walk.
//  - Snapshots every channel on that strobe and applies a per-channel gain and mute.
//  - Accumulates the channels serially with one shared multiplier, then averages

---
 rtl/dkong_audio_pkg.sv | 58 +++++
 rtl/dkong_audio_tick_gen.sv | 37 +++
 rtl/dkong_audio_mixer.sv | 177 +++++++++++++++++
 tb/tb_dkong_audio_mixer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dkong_audio_pkg.sv
// Shared constants, types and helpers for the Donkey Kong sound-board mixer.
// Gains are Q2.6, so GAIN_UNITY corresponds to a shift of GAIN_SHIFT.
package dkong_audio_pkg;

    localparam int unsigned GAIN_UNITY = 64;
    localparam int unsigned GAIN_SHIFT = 6;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DEC,
        OUT
    } mix_state_t;

    typedef struct packed {
        logic        clip;
        logic [15:0] val;
    } sat16_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = unsigned'(i + 1);
            end
        end
        return r;
    endfunction

    // Offset-binary samples become two's complement by flipping the MSB.
    function automatic logic signed [31:0] to_signed_sample(input logic [31:0] dat,
                                                            input int unsigned width,
                                                            input logic is_signed);
        logic [31:0] v;
        v = dat << (32 - width);
        if (!is_signed) begin
            v[31] = ~v[31];
        end
        return $signed(v) >>> (32 - width);
    endfunction

    function automatic sat16_t sat16(input logic signed [63:0] acc);
        sat16_t r;
        if (acc > 64'sd32767) begin
            r.val  = 16'h7FFF;
            r.clip = 1'b1;
        end else if (acc < -64'sd32768) begin
            r.val  = 16'h8000;
            r.clip = 1'b1;
        end else begin
            r.val  = acc[15:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dkong_audio_tick_gen.sv
// Free-running divider producing a one-cycle strobe every CLOCK_RATE/RATE cycles.
// The first strobe appears on the cycle right after reset is released.
module dkong_audio_tick_gen
    import dkong_audio_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 24576000,
    parameter int unsigned RATE       = 96000
) (
    input  logic clk,
    input  logic reset_n,
    output logic strobe
);

    localparam int unsigned TICKS = CLOCK_RATE / RATE;
    localparam int unsigned CNT_W = (clog2(TICKS) > 0) ? clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

    if (TICKS < 1) begin : g_bad_ticks
        $error("dkong_audio_tick_gen: RATE must not exceed CLOCK_RATE");
    end

    logic [CNT_W-1:0] cnt_q;
    logic             strobe_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= LAST;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            strobe_q <= (cnt_q == LAST);
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/dkong_audio_mixer.sv
// N-channel mixer: snapshots channels on the oversample strobe, sums gained samples
// through one shared multiplier, averages OVERSAMPLE groups and saturates to 16 bits.
module dkong_audio_mixer
    import dkong_audio_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned IN_W        = 16,
    parameter int unsigned GAIN_W      = 8,
    parameter int unsigned CLOCK_RATE  = 24576000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned OVERSAMPLE  = 2
) (
    input  logic                     W_CLK_24576M,
    input  logic                     W_RESETn,
    input  logic [NUM_CH*IN_W-1:0]   I_CH_DAT,
    input  logic [NUM_CH-1:0]        I_CH_SIGNED,
    input  logic [NUM_CH*GAIN_W-1:0] I_CH_GAIN,
    input  logic [NUM_CH-1:0]        I_CH_MUTE,
    output logic                     O_OS_CLK_EN,
    output logic [15:0]              O_SOUND_DAT,
    output logic                     O_SAMPLE_VALID,
    output logic                     O_CLIP
);

    localparam int unsigned TICKS     = CLOCK_RATE / (SAMPLE_RATE * OVERSAMPLE);
    localparam int unsigned CH_LOG    = clog2(NUM_CH);
    localparam int unsigned OS_LOG    = clog2(OVERSAMPLE);
    localparam int unsigned CH_W      = (CH_LOG > 0) ? CH_LOG : 1;
    localparam int unsigned OS_W      = (OS_LOG > 0) ? OS_LOG : 1;
    localparam int unsigned PROD_W    = IN_W + GAIN_W + 1;
    localparam int unsigned ACC_W     = PROD_W + CH_LOG + OS_LOG;
    localparam int unsigned OUT_SHIFT = GAIN_SHIFT + OS_LOG;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("dkong_audio_mixer: NUM_CH must be in 1..16");
    end
    if (OVERSAMPLE == 0 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("dkong_audio_mixer: OVERSAMPLE must be a power of 2");
    end
    if (NUM_CH + 3 > TICKS) begin : g_bad_ticks
        $error("dkong_audio_mixer: group does not fit between oversample strobes");
    end
    if (IN_W > 32 || ACC_W > 64) begin : g_bad_width
        $error("dkong_audio_mixer: IN_W or accumulator width too large");
    end

    logic os_clk_en;

    dkong_audio_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .RATE       (SAMPLE_RATE * OVERSAMPLE)
    ) u_tick_gen (
        .clk     (W_CLK_24576M),
        .reset_n (W_RESETn),
        .strobe  (os_clk_en)
    );

    assign O_OS_CLK_EN = os_clk_en;

    // Snapshot holds already-converted samples; a muted channel is stored with zero gain.
    logic signed [IN_W-1:0] samp_q [NUM_CH];
    logic [GAIN_W-1:0]      gain_q [NUM_CH];
    logic                   snap_en;

    always_ff @(posedge W_CLK_24576M) begin
        if (snap_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                samp_q[k] <= IN_W'(to_signed_sample(32'(I_CH_DAT[k*IN_W +: IN_W]), IN_W,
                                                    I_CH_SIGNED[k]));
                gain_q[k] <= I_CH_MUTE[k] ? '0 : I_CH_GAIN[k*GAIN_W +: GAIN_W];
            end
        end
    end

    mix_state_t               state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [OS_W-1:0]          os_q, os_d;
    logic signed [ACC_W-1:0]  group_acc_q, group_acc_d;
    logic signed [ACC_W-1:0]  dec_acc_q, dec_acc_d;
    logic [15:0]              sound_q, sound_d;
    logic                     valid_q, valid_d;
    logic                     clip_q, clip_d;

    // Single shared multiplier, fed by the channel selected by ch_q.
    logic signed [IN_W-1:0]   mul_a;
    logic [GAIN_W-1:0]        mul_b;
    logic signed [PROD_W-1:0] prod;

    assign mul_a = samp_q[ch_q];
    assign mul_b = gain_q[ch_q];
    assign prod  = PROD_W'(mul_a) * PROD_W'($signed({1'b0, mul_b}));

    logic signed [ACC_W-1:0] sum_full;
    logic signed [ACC_W-1:0] shifted;
    sat16_t                  sat;

    assign sum_full = dec_acc_q + group_acc_q;
    assign shifted  = sum_full >>> OUT_SHIFT;
    assign sat      = sat16(64'(shifted));

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        os_d        = os_q;
        group_acc_d = group_acc_q;
        dec_acc_d   = dec_acc_q;
        sound_d     = sound_q;
        valid_d     = 1'b0;
        clip_d      = 1'b0;
        snap_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (os_clk_en) begin
                    snap_en = 1'b1;
                    ch_d    = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                group_acc_d = group_acc_q + ACC_W'(prod);
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = DEC;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            DEC: begin
                dec_acc_d   = sum_full;
                group_acc_d = '0;
                if (os_q == OS_W'(OVERSAMPLE - 1)) begin
                    // Output is registered here so the valid pulse lands in the OUT cycle.
                    os_d    = '0;
                    sound_d = {~sat.val[15], sat.val[14:0]};
                    valid_d = 1'b1;
                    clip_d  = sat.clip;
                    state_d = OUT;
                end else begin
                    os_d    = os_q + OS_W'(1);
                    state_d = IDLE;
                end
            end
            OUT: begin
                dec_acc_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge W_CLK_24576M) begin
        if (!W_RESETn) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            os_q        <= '0;
            group_acc_q <= '0;
            dec_acc_q   <= '0;
            sound_q     <= 16'h8000;
            valid_q     <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            os_q        <= os_d;
            group_acc_q <= group_acc_d;
            dec_acc_q   <= dec_acc_d;
            sound_q     <= sound_d;
            valid_q     <= valid_d;
            clip_q      <= clip_d;
        end
    end

    assign O_SOUND_DAT    = sound_q;
    assign O_SAMPLE_VALID = valid_q;
    assign O_CLIP         = clip_q;

endmodule

// File: tb/tb_dkong_audio_mixer.sv
// Directed bench for dkong_audio_mixer with an arithmetic reference model checked
// on every cycle plus hand-computed literal expectations.
module tb_dkong_audio_mixer;

    localparam int NUM_CH = 4;
    localparam int IN_W   = 16;
    localparam int GAIN_W = 8;
    localparam int OS     = 2;
    localparam int TICKS  = 256;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH*IN_W-1:0]   ch_dat = '0;
    logic [NUM_CH-1:0]        ch_signed = '1;
    logic [NUM_CH*GAIN_W-1:0] ch_gain = '0;
    logic [NUM_CH-1:0]        ch_mute = '1;
    logic                     os_clk_en;
    logic [15:0]              sound_dat;
    logic                     sample_valid;
    logic                     clip;

    dkong_audio_mixer #(
        .NUM_CH      (NUM_CH),
        .IN_W        (IN_W),
        .GAIN_W      (GAIN_W),
        .CLOCK_RATE  (24576000),
        .SAMPLE_RATE (48000),
        .OVERSAMPLE  (OS)
    ) dut (
        .W_CLK_24576M   (clk),
        .W_RESETn       (rst_n),
        .I_CH_DAT       (ch_dat),
        .I_CH_SIGNED    (ch_signed),
        .I_CH_GAIN      (ch_gain),
        .I_CH_MUTE      (ch_mute),
        .O_OS_CLK_EN    (os_clk_en),
        .O_SOUND_DAT    (sound_dat),
        .O_SAMPLE_VALID (sample_valid),
        .O_CLIP         (clip)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state, advanced at every rising edge.
    int          since = 0;
    longint      m_acc = 0;
    int          m_grp = 0;
    int          pend_at = -1;
    logic [15:0] pend_dat = 16'h8000;
    logic        pend_clip = 1'b0;
    logic        exp_os = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_clip = 1'b0;
    logic [15:0] exp_dat = 16'h8000;

    function automatic longint group_sum();
        longint s = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            logic [15:0] d;
            longint      v;
            d = ch_dat[k*IN_W +: IN_W];
            v = ch_signed[k] ? longint'($signed(d)) : longint'(d) - 32768;
            if (!ch_mute[k]) s += v * longint'(ch_gain[k*GAIN_W +: GAIN_W]);
        end
        return s;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                since     = 0;
                m_acc     = 0;
                m_grp     = 0;
                pend_at   = -1;
                exp_os    = 1'b0;
                exp_valid = 1'b0;
                exp_clip  = 1'b0;
                exp_dat   = 16'h8000;
            end else begin
                if (exp_os) begin
                    m_acc += group_sum();
                    m_grp++;
                    if (m_grp == OS) begin
                        longint div, y;
                        div = 64 * OS;
                        y = m_acc / div;
                        if ((m_acc % div != 0) && (m_acc < 0)) y -= 1;
                        pend_clip = (y > 32767) || (y < -32768);
                        if (y > 32767) y = 32767;
                        if (y < -32768) y = -32768;
                        pend_dat = 16'(y + 32768);
                        pend_at  = since + NUM_CH + 2;
                        m_acc = 0;
                        m_grp = 0;
                    end
                end
                since++;
                exp_os    = ((since - 1) % TICKS) == 0;
                exp_valid = (since == pend_at);
                exp_clip  = exp_valid && pend_clip;
                if (exp_valid) exp_dat = pend_dat;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        n_tests++;
        if (os_clk_en !== exp_os || sample_valid !== exp_valid || clip !== exp_clip ||
            sound_dat !== exp_dat) begin
            n_fail++;
            $display("FAIL cycle %0d model: os/valid/clip/dat got %b/%b/%b/%h want %b/%b/%b/%h",
                     cyc, os_clk_en, sample_valid, clip, sound_dat,
                     exp_os, exp_valid, exp_clip, exp_dat);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_os(input string name, output int at);
        int n = 0;
        at = -1;
        do begin
            step();
            n++;
        end while (os_clk_en !== 1'b1 && n < 300);
        n_tests++;
        if (os_clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: no strobe within %0d cycles", name, n);
        end else begin
            at = cyc;
        end
    endtask

    task automatic wait_valid(input string name, output int at);
        int n = 0;
        at = -1;
        do begin
            step();
            n++;
        end while (sample_valid !== 1'b1 && n < 1200);
        n_tests++;
        if (sample_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: no valid pulse within %0d cycles", name, n);
        end else begin
            at = cyc;
        end
    endtask

    task automatic set_ch(input int k, input logic [15:0] d, input logic s,
                          input logic [7:0] g, input logic m);
        ch_dat[k*IN_W +: IN_W]     = d;
        ch_signed[k]               = s;
        ch_gain[k*GAIN_W +: GAIN_W] = g;
        ch_mute[k]                 = m;
    endtask

    initial begin
        int t0, t1, t2, v1, v2, outs, n, seen;

        repeat (10) step();
        check("reset_dat", 32'(sound_dat), 32'h8000);
        check("reset_valid", 32'(sample_valid), 0);
        check("reset_clip", 32'(clip), 0);
        check("reset_os", 32'(os_clk_en), 0);

        // Single signed channel at unity gain.
        set_ch(0, 16'h1000, 1'b1, 8'd64, 1'b0);
        rst_n = 1'b1;
        t0 = cyc;
        wait_os("first_strobe", t1);
        check("first_strobe_delay", 32'(t1 - t0), 1);
        wait_os("second_strobe", t2);
        check("strobe_period", 32'(t2 - t1), 256);
        wait_valid("unity_v1", v1);
        check("valid_after_strobe", 32'(v1 - t2), NUM_CH + 2);
        check("unity_dat", 32'(sound_dat), 32'h9000);
        check("unity_clip", 32'(clip), 0);
        wait_valid("unity_v2", v2);
        check("valid_period", 32'(v2 - v1), 512);
        check("unity_dat2", 32'(sound_dat), 32'h9000);

        // Offset-binary channel at half gain.
        set_ch(0, 16'hC000, 1'b0, 8'd32, 1'b0);
        wait_valid("offbin_v1", v1);
        wait_valid("offbin_v2", v2);
        check("offbin_dat", 32'(sound_dat), 32'hA000);
        check("offbin_clip", 32'(clip), 0);

        // Full-scale positive and negative saturation.
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'h7FFF, 1'b1, 8'd255, 1'b0);
        wait_valid("satpos_v1", v1);
        wait_valid("satpos_v2", v2);
        check("satpos_dat", 32'(sound_dat), 32'hFFFF);
        check("satpos_clip", 32'(clip), 1);
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'h8000, 1'b1, 8'd255, 1'b0);
        wait_valid("satneg_v1", v1);
        wait_valid("satneg_v2", v2);
        check("satneg_dat", 32'(sound_dat), 32'h0000);
        check("satneg_clip", 32'(clip), 1);

        // Small negative result must round toward minus infinity.
        ch_mute = '1;
        set_ch(0, 16'hFFFF, 1'b1, 8'd1, 1'b0);
        wait_valid("floor_v1", v1);
        wait_valid("floor_v2", v2);
        check("floor_dat", 32'(sound_dat), 32'h7FFF);
        check("floor_clip", 32'(clip), 0);

        // Alternating input averages across the oversample pair.
        set_ch(0, 16'h0000, 1'b1, 8'd64, 1'b0);
        outs = 0;
        n = 0;
        while (outs < 4 && n < 2500) begin
            step();
            n++;
            if (os_clk_en) ch_dat[15:0] = (ch_dat[15:0] == 16'h2000) ? 16'h0000 : 16'h2000;
            if (sample_valid) begin
                outs++;
                if (outs > 1) check("toggle_avg", 32'(sound_dat), 32'h9000);
            end
        end
        check("toggle_outputs", 32'(outs), 4);

        // Two channels, then a reset pulse in the middle of accumulation.
        set_ch(0, 16'h1000, 1'b1, 8'd64, 1'b0);
        set_ch(1, 16'h9000, 1'b0, 8'd128, 1'b0);
        wait_valid("mix_v1", v1);
        wait_valid("mix_v2", v2);
        check("mix_dat", 32'(sound_dat), 32'hB000);
        wait_os("abort_s1", t1);
        wait_os("abort_s2", t2);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sample_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 0);
        check("abort_dat", 32'(sound_dat), 32'h8000);
        wait_valid("after_abort_v1", v1);
        check("after_abort_dat", 32'(sound_dat), 32'hB000);
        check("after_abort_clip", 32'(clip), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
